// File: rtl/ram8_block_engine_pkg.sv
// Shared definitions for the RAM8 block engine: default widths, op codes, FSM states.
package ram8_block_engine_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_LEN_W  = DEF_ADDR_W + 1;

    typedef enum logic [1:0] {
        OP_FILL = 2'd0,
        OP_COPY = 2'd1,
        OP_SUM  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/ram8_block_engine_addr_gen.sv
// Window address generator: base + offset, wrapping modulo the RAM depth.
// Purely combinational; shared by the read (src) and write (dst) paths.
module ram8_block_engine_addr_gen #(
    parameter int ADDR_W = 3
) (
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] cnt_i,
    output logic [ADDR_W-1:0] addr_o
);

    // Truncation to ADDR_W bits gives the 7->0 wrap for free.
    assign addr_o = base_i + cnt_i;

endmodule

// File: rtl/ram8_block_engine.sv
// Block command engine (FILL/COPY/SUM) driving an 8-word register RAM over a wrapping window.
// FILL/SUM take N cycles and COPY 2N, plus one FIN cycle; start is ignored while busy.
module ram8_block_engine
    import ram8_block_engine_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [DATA_W-1:0] fill_val_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] result_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_load_o,
    output logic [DATA_W-1:0] ram_in_o,
    input  logic [DATA_W-1:0] ram_out_i
);

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(2 ** ADDR_W);

    state_e            state_q;
    op_e               op_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] result_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              last;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] win_addr;

    assign last = (cnt_q == len_q - 1'b1);
    assign base = (state_q == ST_WR) ? dst_q : src_q;

    ram8_block_engine_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .base_i (base),
        .cnt_i  (cnt_q[ADDR_W-1:0]),
        .addr_o (win_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_FILL;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            fill_q   <= '0;
            data_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        op_q   <= op_e'(op_i);
                        src_q  <= src_i;
                        dst_q  <= dst_i;
                        len_q  <= len_i;
                        fill_q <= fill_val_i;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (op_e'(op_i) == OP_RSVD || len_i > DEPTH_L) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (len_i == '0) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else if (op_e'(op_i) == OP_FILL) begin
                            state_q <= ST_WR;
                        end else begin
                            state_q <= ST_RD;
                            if (op_e'(op_i) == OP_SUM) begin
                                result_q <= '0;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (op_q == OP_COPY) begin
                        data_q  <= ram_out_i;
                        state_q <= ST_WR;
                    end else begin
                        result_q <= result_q + ram_out_i;
                        cnt_q    <= cnt_q + 1'b1;
                        if (last) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                    end else if (op_q == OP_FILL) begin
                        state_q <= ST_WR;
                    end else begin
                        state_q <= ST_RD;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // RAM port is a pure decode of registered state, so load falls with the async reset.
    assign ram_load_o = (state_q == ST_WR);
    assign ram_addr_o = (state_q == ST_RD || state_q == ST_WR) ? win_addr : '0;
    assign ram_in_o   = (state_q != ST_WR) ? '0 :
                        (op_q == OP_FILL)  ? fill_q : data_q;

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_ram8_block_engine.sv
// Directed bench for ram8_block_engine with an 8x16 RAM responder, reference RAM model and scoreboards.
module tb_ram8_block_engine;
    import ram8_block_engine_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [2:0]  src_i;
    logic [2:0]  dst_i;
    logic [3:0]  len_i;
    logic [15:0] fill_val_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [15:0] result_o;
    logic [2:0]  ram_addr_o;
    logic        ram_load_o;
    logic [15:0] ram_in_o;
    logic [15:0] ram_out_i;

    logic [15:0] mem [8];
    logic [15:0] exp_mem [8];
    logic        bd_we;
    logic [2:0]  bd_addr;
    logic [15:0] bd_dat;

    typedef struct packed {
        logic        err;
        logic        is_sum;
        logic [15:0] res;
        int          lat;
        int          nwr;
    } exp_t;

    exp_t        sb_q [$];
    logic [18:0] wr_q [$];

    int n_cmp = 0;
    int n_err = 0;

    ram8_block_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .src_i      (src_i),
        .dst_i      (dst_i),
        .len_i      (len_i),
        .fill_val_i (fill_val_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .result_o   (result_o),
        .ram_addr_o (ram_addr_o),
        .ram_load_o (ram_load_o),
        .ram_in_o   (ram_in_o),
        .ram_out_i  (ram_out_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Eight-register RAM responder with a backdoor port for preloading.
    always @(posedge clk) begin
        if (ram_load_o) mem[ram_addr_o] <= ram_in_o;
        else if (bd_we) mem[bd_addr] <= bd_dat;
    end
    assign ram_out_i = mem[ram_addr_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Every RAM write is checked against the queue of writes the model predicted.
    always @(negedge clk) begin
        logic [18:0] ew;
        if (rst_n && ram_load_o) begin
            ew = (wr_q.size() > 0) ? wr_q.pop_front() : 19'bx;
            chk("ram_write", 32'({ram_addr_o, ram_in_o}), 32'(ew));
        end
    end

    task automatic poke_mem(input logic [2:0] a, input logic [15:0] d);
        bd_we = 1'b1; bd_addr = a; bd_dat = d;
        @(negedge clk);
        bd_we = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic chk_mem(input string tag);
        for (int i = 0; i < 8; i++) chk($sformatf("%s_mem%0d", tag, i), 32'(mem[i]), 32'(exp_mem[i]));
    endtask

    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [2:0] src,
                          input logic [2:0] dst, input logic [3:0] len, input logic [15:0] val,
                          input int poke_at);
        exp_t        e;
        logic [2:0]  a;
        logic [15:0] d;
        int          lat;
        int          nbusy;
        int          nload;
        logic        err_s;
        logic [15:0] res_s;
        e = '0;
        e.is_sum = (op == OP_SUM);
        if (op == OP_RSVD || len > 4'd8) begin
            e.err = 1'b1; e.lat = 1;
        end else if (len == 4'd0) begin
            e.lat = 1;
        end else begin
            e.lat = (op == OP_COPY) ? 2 * int'(len) + 1 : int'(len) + 1;
            for (int i = 0; i < int'(len); i++) begin
                if (op == OP_SUM) begin
                    e.res = e.res + exp_mem[src + 3'(i)];
                end else begin
                    a = dst + 3'(i);
                    d = (op == OP_FILL) ? val : exp_mem[src + 3'(i)];
                    exp_mem[a] = d;
                    wr_q.push_back({a, d});
                    e.nwr++;
                end
            end
        end
        sb_q.push_back(e);

        op_i = op; src_i = src; dst_i = dst; len_i = len; fill_val_i = val; start_i = 1'b1;
        lat = 0; nbusy = 0; nload = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy_o) nbusy++;
            if (ram_load_o) nload++;
            if (lat == poke_at) begin
                start_i = 1'b1; op_i = OP_FILL; src_i = 3'd0; dst_i = 3'd0;
                len_i = 4'd8; fill_val_i = 16'h0000;
            end else begin
                start_i = 1'b0;
            end
        end while (!done_o && lat < 40);
        err_s = err_o;
        res_s = result_o;
        @(negedge clk);
        start_i = 1'b0;

        e = sb_q.pop_front();
        chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
        chk({tag, "_err"}, 32'(err_s), 32'(e.err));
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(e.lat));
        chk({tag, "_load_cycles"}, 32'(nload), 32'(e.nwr));
        chk({tag, "_idle_busy"}, 32'(busy_o), 32'(0));
        chk({tag, "_done_pulse"}, 32'(done_o), 32'(0));
        if (e.is_sum && !e.err && len != 4'd0) chk({tag, "_result"}, 32'(res_s), 32'(e.res));
        chk_mem(tag);
    endtask

    initial begin
        int lat;
        int nload;
        int sawdone;
        rst_n = 1'b0; start_i = 1'b0; op_i = 2'd0; src_i = '0; dst_i = '0; len_i = '0;
        fill_val_i = '0; bd_we = 1'b0; bd_addr = '0; bd_dat = '0;

        @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_done", 32'(done_o), 32'(0));
        chk("rst_err", 32'(err_o), 32'(0));
        chk("rst_load", 32'(ram_load_o), 32'(0));
        chk("rst_result", 32'(result_o), 32'(0));
        chk("rst_addr", 32'(ram_addr_o), 32'(0));
        chk("rst_in", 32'(ram_in_o), 32'(0));
        for (int i = 0; i < 8; i++) poke_mem(3'(i), 16'h0100 + 16'(i));
        rst_n = 1'b1;
        @(negedge clk);

        // FILL with a stray start (and changed inputs) mid-command.
        do_cmd("fill", OP_FILL, 3'd0, 3'd2, 4'd3, 16'hBEEF, 2);

        for (int i = 0; i < 8; i++) poke_mem(3'(i), 16'(i + 1));
        do_cmd("sum_wrap", OP_SUM, 3'd6, 3'd0, 4'd4, 16'h0000, 0);

        poke_mem(3'd0, 16'hAAAA); poke_mem(3'd1, 16'hBBBB); poke_mem(3'd2, 16'hCCCC);
        do_cmd("copy", OP_COPY, 3'd0, 3'd5, 4'd3, 16'h0000, 0);

        for (int i = 0; i < 8; i++) poke_mem(3'(i), 16'hFFFF);
        do_cmd("sum_full", OP_SUM, 3'd3, 3'd0, 4'd8, 16'h0000, 0);
        do_cmd("rsvd", OP_RSVD, 3'd0, 3'd0, 4'd2, 16'h1234, 0);
        do_cmd("len0", OP_FILL, 3'd0, 3'd1, 4'd0, 16'h5555, 1);
        do_cmd("len9", OP_COPY, 3'd0, 3'd1, 4'd9, 16'h0000, 0);

        // Overlapping forward copy smears the first word along.
        for (int i = 0; i < 8; i++) poke_mem(3'(i), 16'h2000 + 16'(i));
        do_cmd("overlap", OP_COPY, 3'd0, 3'd1, 4'd3, 16'h0000, 0);
        do_cmd("fill_len8", OP_FILL, 3'd0, 3'd3, 4'd8, 16'h0F0F, 0);

        // Reset during the third write of a COPY.
        poke_mem(3'd0, 16'hA0A0); poke_mem(3'd1, 16'hB0B0); poke_mem(3'd2, 16'hC0C0);
        wr_q.push_back({3'd5, 16'hA0A0});
        wr_q.push_back({3'd6, 16'hB0B0});
        wr_q.push_back({3'd7, 16'hC0C0});
        exp_mem[5] = 16'hA0A0;
        exp_mem[6] = 16'hB0B0;
        op_i = OP_COPY; src_i = 3'd0; dst_i = 3'd5; len_i = 4'd3; start_i = 1'b1;
        lat = 0; nload = 0;
        do begin
            @(negedge clk);
            start_i = 1'b0;
            lat++;
            if (ram_load_o) nload++;
        end while (nload < 3 && lat < 20);
        chk("rstcopy_third_write_cycle", 32'(lat), 32'(6));
        #2 rst_n = 1'b0;
        #1;
        chk("rstcopy_load_drop", 32'(ram_load_o), 32'(0));
        chk("rstcopy_busy_drop", 32'(busy_o), 32'(0));
        chk("rstcopy_done", 32'(done_o), 32'(0));
        chk("rstcopy_result", 32'(result_o), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sawdone = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_o || busy_o) sawdone++;
        end
        chk("rstcopy_no_done", 32'(sawdone), 32'(0));
        chk_mem("rstcopy");
        do_cmd("fill_after_rst", OP_FILL, 3'd0, 3'd6, 4'd4, 16'h1234, 0);

        chk("writes_drained", 32'(wr_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
